// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART blocks: receiver FSM encoding,
// parity-mode constants and small helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 32'sd0;
  localparam int PARITY_EVEN = 32'sd1;
  localparam int PARITY_ODD  = 32'sd2;

  // Cycles per bit, rounded to the nearest integer.
  function automatic int CLK_DIV_FROM(input int clk_hz, input int baud);
    return (clk_hz + (baud / 32'sd2)) / baud;
  endfunction

  // Parity bit a transmitter sends for this data (unused upper bits must be 0).
  function automatic logic parity_expected(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the half-bit and
// full-bit points. restart_i holds/forces the count to zero.
module uart_baud_tick #(
  parameter int CLK_DIV = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign half_tick_o = (cnt_q == HALF_M1);
  assign full_tick_o = (cnt_q == FULL_M1);

  // Next count: restart, wrap at the end of a bit, otherwise increment.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (full_tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised input, false-start rejection,
// optional parity, 1 or 2 stop bits, and a valid/ready output register that
// reports framing, parity and overrun errors.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic       HAS_PARITY = (PARITY_MODE != PARITY_NONE) ? 1'b1 : 1'b0;

  // Synchroniser and sampled line.
  logic sync1_q;
  logic sync2_q;
  logic rx_s;

  // Frame assembly state.
  rx_state_e            state_q, state_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 seen_high_q, seen_high_d;

  // Output register.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  logic restart_s;
  logic half_tick_s;
  logic full_tick_s;

  assign rx_s          = sync2_q;
  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = busy_q;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk_i      (clk),
    .rst_i      (rst),
    .restart_i  (restart_s),
    .half_tick_o(half_tick_s),
    .full_tick_o(full_tick_s)
  );

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM: next state, sampling and error accumulation.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shreg_d     = shreg_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    seen_high_d = seen_high_q;
    restart_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        restart_s = 1'b1;
        if (rx_s) begin
          seen_high_d = 1'b1;
        end else if (seen_high_q) begin
          // A start is only accepted once the line has been idle-high,
          // so a held-low break does not retrigger frames.
          state_d     = ST_START;
          seen_high_d = 1'b0;
          par_err_d   = 1'b0;
          frm_err_d   = 1'b0;
        end else begin
          seen_high_d = seen_high_q;
        end
      end
      ST_START: begin
        if (half_tick_s) begin
          restart_s = 1'b1;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = 4'd0;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (full_tick_s) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d    = HAS_PARITY ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (full_tick_s) begin
          par_err_d  = (rx_s != parity_expected(9'(shreg_q), PARITY_MODE));
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (full_tick_s) begin
          if (!rx_s) begin
            frm_err_d = 1'b1;
          end else begin
            frm_err_d = frm_err_q;
          end
          if (stop_idx_q == LAST_STOP) begin
            state_d = ST_DONE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_DONE: begin
        restart_s = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        restart_s = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Frame FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= 4'd0;
      stop_idx_q  <= 1'b0;
      shreg_q     <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      seen_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shreg_q     <= shreg_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      seen_high_q <= seen_high_d;
    end
  end

  // Output register: hand off completed words, flag drops when the consumer stalls.
  always_comb begin
    data_d = data_q;
    ferr_d = ferr_q;
    perr_d = perr_q;
    ovr_d  = 1'b0;
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (state_q == ST_DONE) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        ferr_d  = frm_err_q;
        perr_d  = par_err_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      ovr_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

endmodule
